// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Central sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline buffers.
//   Produces per-stage load enables and bubble (flush) controls, resolves
//   load-use stalls, taken branch/JAL squash and data-memory wait stalls,
//   runs the halt drain sequence and keeps saturating stall/flush counters.
// Ports
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   id_rs1/id_rs2        source register fields of the IF/ID instruction
//   id_uses_rs2          IF/ID instruction reads rs2
//   id_halt              halt marker in IF/ID
//   ex_memread, ex_rd    load flag and destination of the ID/EX instruction
//   ex_redirect          taken branch / JAL resolved in EX this cycle
//   mem_req, dmem_ready  EX/MEM memory access and its completion
//   wb_halt              halt marker in MEM/WB
//   pc_we .. memwb_we    stage load enables; *_flush loads a zero bubble
//   halted, mem_timeout  registered status (mem_timeout is sticky)
//   stall_count          load-use + memory-wait stall cycles, saturating
//   flush_count          redirect events, saturating
module pipe_hazard_ctrl #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned MEM_TO = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic             id_halt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             dmem_ready,
  input  logic             wb_halt,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_flush,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] MEM_TO_C  = CNT_W'(MEM_TO);
  localparam logic [CNT_W-1:0] MEM_TO_M1 = CNT_W'(MEM_TO - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_wait, load_use;
  logic             wait_ev, stall_ev, flush_ev;

  assign mem_wait = mem_req & ~dmem_ready;
  assign load_use = ex_memread & (ex_rd != 5'd0) &
                    ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));

  always_comb begin
    pc_we      = 1'b0;
    ifid_we    = 1'b0;
    ifid_flush = 1'b0;
    idex_we    = 1'b0;
    idex_flush = 1'b0;
    exmem_we   = 1'b0;
    memwb_we   = 1'b0;
    wait_ev    = 1'b0;
    stall_ev   = 1'b0;
    flush_ev   = 1'b0;
    state_nx   = state;

    if (state == HALTED) begin
      state_nx = HALTED;
    end else if (mem_wait) begin
      wait_ev  = 1'b1;
      stall_ev = 1'b1;
    end else if (ex_redirect) begin
      // Same squash in RUN and DRAIN; a halt in ID is discarded with it.
      pc_we      = 1'b1;
      ifid_we    = 1'b1;
      ifid_flush = 1'b1;
      idex_we    = 1'b1;
      idex_flush = 1'b1;
      exmem_we   = 1'b1;
      memwb_we   = 1'b1;
      flush_ev   = 1'b1;
    end else if (state == DRAIN) begin
      // IF/ID only ever holds bubbles here, so load-use cannot arise.
      ifid_we    = 1'b1;
      ifid_flush = 1'b1;
      idex_we    = 1'b1;
      exmem_we   = 1'b1;
      memwb_we   = 1'b1;
    end else if (load_use) begin
      idex_we    = 1'b1;
      idex_flush = 1'b1;
      exmem_we   = 1'b1;
      memwb_we   = 1'b1;
      stall_ev   = 1'b1;
    end else begin
      pc_we    = 1'b1;
      ifid_we  = 1'b1;
      idex_we  = 1'b1;
      exmem_we = 1'b1;
      memwb_we = 1'b1;
      if (id_halt) state_nx = DRAIN;
    end

    // Halt reaching WB ends the drain even while memory is still waiting.
    if (state == DRAIN && wb_halt) state_nx = HALTED;

    if (reset) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      ifid_flush = 1'b0;
      idex_we    = 1'b0;
      idex_flush = 1'b0;
      exmem_we   = 1'b0;
      memwb_we   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      halted      <= 1'b0;
      mem_timeout <= 1'b0;
      wait_cnt    <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state  <= state_nx;
      halted <= (state_nx == HALTED);
      if (wait_ev) begin
        if (wait_cnt != MEM_TO_C) wait_cnt <= wait_cnt + 1'b1;
        // This wait cycle makes the consecutive total reach MEM_TO.
        if (wait_cnt >= MEM_TO_M1) mem_timeout <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (stall_ev && stall_count != CNT_MAX) stall_count <= stall_count + 1'b1;
      if (flush_ev && flush_count != CNT_MAX) flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
//   Directed-vector bench for pipe_hazard_ctrl with small counters (CNT_W=3)
//   so saturation is reachable, and MEM_TO=2 for the memory-wait timeout.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs2, id_halt, ex_memread, ex_redirect;
  logic       mem_req, dmem_ready, wb_halt;
  logic       pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_we;
  logic       halted, mem_timeout;
  logic [2:0] stall_count, flush_count;
  logic [7:0] ctrl;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // ctrl bits: 6 pc_we, 5 ifid_we, 4 ifid_flush, 3 idex_we, 2 idex_flush, 1 exmem_we, 0 memwb_we
  localparam logic [7:0] ALL     = 8'h7F;
  localparam logic [7:0] NORMAL  = 8'h6B;
  localparam logic [7:0] M_LU    = 8'h77;  // idex_we irrelevant under flush
  localparam logic [7:0] E_LU    = 8'h07;
  localparam logic [7:0] M_RDR   = 8'h57;  // ifid_we/idex_we irrelevant under flush
  localparam logic [7:0] E_RDR   = 8'h57;
  localparam logic [7:0] M_DRAIN = 8'h5F;  // ifid_we irrelevant under flush
  localparam logic [7:0] E_DRAIN = 8'h1B;

  assign ctrl = {1'b0, pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_we};

  pipe_hazard_ctrl #(.CNT_W(3), .MEM_TO(2)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2), .id_halt(id_halt),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .dmem_ready(dmem_ready), .wb_halt(wb_halt),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .idex_we(idex_we), .idex_flush(idex_flush), .exmem_we(exmem_we), .memwb_we(memwb_we),
    .halted(halted), .mem_timeout(mem_timeout),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_uses_rs2 = 1'b0; id_halt = 1'b0; ex_memread = 1'b0; ex_redirect = 1'b0;
    mem_req = 1'b0; dmem_ready = 1'b1; wb_halt = 1'b0;
  endtask

  // Advance to just after the next rising edge; inputs change there.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use_rs1();
    idle(); ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
  endtask

  task automatic mem_stall();
    idle(); mem_req = 1'b1; dmem_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #3;
    check("rst_ctrl", ctrl, 8'h00);
    check("rst_halted", {7'd0, halted}, 8'h00);
    check("rst_stall", {5'd0, stall_count}, 8'h00);
    check("rst_flush", {5'd0, flush_count}, 8'h00);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    idle(); #1;
    check("normal", ctrl, NORMAL);

    cyc(); load_use_rs1(); #1;
    check("lu_rs1", ctrl & M_LU, E_LU);

    cyc(); idle(); ex_memread = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7;
    id_uses_rs2 = 1'b1; #1;
    check("lu_rs2", ctrl & M_LU, E_LU);
    check("stall_1", {5'd0, stall_count}, 8'd1);

    cyc(); id_uses_rs2 = 1'b0; #1;
    check("rs2_unused", ctrl, NORMAL);
    check("stall_2", {5'd0, stall_count}, 8'd2);

    cyc(); idle(); ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs2 = 1'b1; #1;
    check("x0_guard", ctrl, NORMAL);

    cyc(); load_use_rs1(); ex_redirect = 1'b1; #1;
    check("rdr_lu", ctrl & M_RDR, E_RDR);
    check("x0_stall", {5'd0, stall_count}, 8'd2);

    cyc(); mem_stall(); #1;
    check("wait1", ctrl, 8'h00);
    check("rdr_flush", {5'd0, flush_count}, 8'd1);
    check("rdr_stall", {5'd0, stall_count}, 8'd2);
    check("wait1_to", {7'd0, mem_timeout}, 8'd0);
    cyc(); #1;
    check("wait2", ctrl, 8'h00);
    check("wait2_to", {7'd0, mem_timeout}, 8'd0);
    cyc(); #1;
    check("wait3", ctrl, 8'h00);
    check("wait3_to", {7'd0, mem_timeout}, 8'd1);
    cyc(); dmem_ready = 1'b1; #1;
    check("ready", ctrl, NORMAL);
    check("wait_stall", {5'd0, stall_count}, 8'd5);
    check("to_sticky", {7'd0, mem_timeout}, 8'd1);

    for (int i = 0; i < 3; i++) begin
      cyc(); load_use_rs1(); #1;
    end
    cyc(); idle(); #1;
    check("stall_sat", {5'd0, stall_count}, 8'd7);
    check("to_sticky2", {7'd0, mem_timeout}, 8'd1);

    idle(); id_halt = 1'b1; ex_redirect = 1'b1; #1;
    check("halt_rdr", ctrl & M_RDR, E_RDR);
    cyc(); idle(); #1;
    check("halt_squash", ctrl, NORMAL);
    check("squash_halted", {7'd0, halted}, 8'd0);
    check("flush_2", {5'd0, flush_count}, 8'd2);

    cyc(); id_halt = 1'b1; #1;
    check("halt_enter", ctrl, NORMAL);
    cyc(); idle(); #1;
    check("drain", ctrl & M_DRAIN, E_DRAIN);
    #2 reset = 1'b1;
    #1;
    check("arst_ctrl", ctrl, 8'h00);
    check("arst_stall", {5'd0, stall_count}, 8'd0);
    check("arst_flush", {5'd0, flush_count}, 8'd0);
    check("arst_to", {7'd0, mem_timeout}, 8'd0);
    cyc(); reset = 1'b0; idle(); #1;
    check("post_rst_run", ctrl, NORMAL);

    cyc(); id_halt = 1'b1; #1;
    check("halt2_enter", ctrl, NORMAL);
    cyc(); idle(); ex_redirect = 1'b1; #1;
    check("drain_rdr", ctrl & M_RDR, E_RDR);
    cyc(); mem_stall(); #1;
    check("drain_wait", ctrl, 8'h00);
    check("drain_flush", {5'd0, flush_count}, 8'd1);
    cyc(); mem_stall(); wb_halt = 1'b1; #1;
    check("wb_halt_wait", ctrl, 8'h00);
    check("pre_halted", {7'd0, halted}, 8'd0);
    cyc(); mem_stall(); #1;
    check("halted_ctrl", ctrl, 8'h00);
    check("halted_1", {7'd0, halted}, 8'd1);
    check("drain_to", {7'd0, mem_timeout}, 8'd1);
    cyc(); idle(); id_halt = 1'b1; #1;
    check("halted_hold", ctrl, 8'h00);
    check("halted_2", {7'd0, halted}, 8'd1);
    check("halted_stall", {5'd0, stall_count}, 8'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
